ahb_sram_sub: RTL and testbench

AHB_SRAM_SUB -- requirements
Module: ahb_sram_sub

---
 rtl/ahb_sram_sub_pkg.sv | 38 +++
 rtl/ahb_sram_sub_if.sv | 26 ++
 rtl/ahb_sram_sub_strb_gen.sv | 29 ++
 rtl/ahb_sram_sub.sv | 149 ++++++++++++++
 tb/tb_ahb_sram_sub.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_sram_sub_pkg.sv
// rtl/ahb_sram_sub_pkg.sv - shared bus widths, AHB encodings and slave sub-state enum
package param_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    typedef enum logic [1:0] {
        SUB_IDLE,
        SUB_WAIT,
        SUB_ERR1,
        SUB_ERR2
    } sub_state_t;

    // NONSEQ and SEQ carry a real transfer; IDLE and BUSY never touch the slave
    function automatic logic is_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_sram_sub_if.sv
// rtl/ahb_sram_sub_if.sv - AHB-Lite slave bus bundle with master/slave views
interface ahb_sram_sub_if;
    import param_pkg::*;

    logic                  Hsel;
    logic [ADDR_WIDTH-1:0] Haddr;
    logic [1:0]            Htrans;
    logic                  Hwrite;
    logic [2:0]            Hsize;
    logic                  Hready;
    logic [DATA_WIDTH-1:0] Hwdata;
    logic [DATA_WIDTH-1:0] Hrdata;
    logic                  Hreadyout;
    logic                  Hresp;

    modport master (
        output Hsel, Haddr, Htrans, Hwrite, Hsize, Hready, Hwdata,
        input  Hrdata, Hreadyout, Hresp
    );

    modport slave (
        input  Hsel, Haddr, Htrans, Hwrite, Hsize, Hready, Hwdata,
        output Hrdata, Hreadyout, Hresp
    );

endinterface

// File: rtl/ahb_sram_sub_strb_gen.sv
// rtl/ahb_sram_sub_strb_gen.sv - byte-lane strobe and alignment/size error from address and size
module ahb_strb_gen
    import param_pkg::*;
(
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            hsize,
    output logic [STRB_WIDTH-1:0] strb,
    output logic                  err
);

    // Lane mask shifted to the addressed byte; misaligned or oversized transfers flag an error
    always_comb begin
        strb = '0;
        err  = 1'b0;
        case (hsize)
            HSIZE_BYTE: strb = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                strb = 4'b0011 << addr_lo;
                err  = addr_lo[0];
            end
            HSIZE_WORD: begin
                strb = 4'b1111;
                err  = (addr_lo != 2'b00);
            end
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_sram_sub.sv
// rtl/ahb_sram_sub.sv - AHB-Lite SRAM slave, wait states enabled by macro AHB_SUB_WAIT_EN
module ahb_sram_sub
    import param_pkg::*;
#(
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic           Hclk,
    input logic           Hresetn,
    ahb_sram_sub_if.slave bus
);

    localparam int                    IDX_W       = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-3:0] DEPTH_WORDS = (ADDR_WIDTH-2)'(MEM_DEPTH);

    sub_state_t            state_q, state_d;
    logic                  dp_valid_q, dp_valid_d;
    logic                  dp_write_q, dp_write_d;
    logic [IDX_W-1:0]      dp_idx_q, dp_idx_d;
    logic [STRB_WIDTH-1:0] dp_strb_q, dp_strb_d;
`ifdef AHB_SUB_WAIT_EN
    logic [3:0]            cnt_q, cnt_d;
`endif

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [STRB_WIDTH-1:0] addr_strb;
    logic                  size_err;
    logic                  addr_err;
    logic                  accept;
    logic                  complete;
    logic                  hreadyout;
    logic                  unused_cfg;

    // WAIT_CYCLES only shapes the wait counter; without wait support it has no effect
    assign unused_cfg = (WAIT_CYCLES > 15);

    ahb_strb_gen u_strb_gen (
        .addr_lo (bus.Haddr[1:0]),
        .hsize   (bus.Hsize),
        .strb    (addr_strb),
        .err     (size_err)
    );

    // Address-phase qualification and error classification of the incoming transfer
    always_comb begin
        addr_err = size_err || (bus.Haddr[ADDR_WIDTH-1:2] >= DEPTH_WORDS);
        accept   = bus.Hsel && bus.Hready && is_active(bus.Htrans) && hreadyout;
    end

    // Bus outputs decoded from the sub-state; read data is driven only in the completing read cycle
    always_comb begin
        hreadyout = 1'b1;
        bus.Hresp = HRESP_OKAY;
        case (state_q)
            SUB_WAIT: hreadyout = 1'b0;
            SUB_ERR1: begin
                hreadyout = 1'b0;
                bus.Hresp = HRESP_ERROR;
            end
            SUB_ERR2: bus.Hresp = HRESP_ERROR;
            default:  ;
        endcase
        complete   = (state_q == SUB_IDLE) && dp_valid_q;
        bus.Hrdata = (complete && !dp_write_q) ? mem[dp_idx_q] : '0;
    end

    assign bus.Hreadyout = hreadyout;

    // Next state: capture accepted transfers, count wait states, sequence the two-cycle error
    always_comb begin
        state_d    = state_q;
        dp_valid_d = dp_valid_q;
        dp_write_d = dp_write_q;
        dp_idx_d   = dp_idx_q;
        dp_strb_d  = dp_strb_q;
`ifdef AHB_SUB_WAIT_EN
        cnt_d      = cnt_q;
`endif
        case (state_q)
            SUB_IDLE, SUB_ERR2: begin
                state_d    = SUB_IDLE;
                dp_valid_d = 1'b0;
                if (accept) begin
                    if (addr_err) begin
                        state_d = SUB_ERR1;
                    end else begin
                        dp_valid_d = 1'b1;
                        dp_write_d = bus.Hwrite;
                        dp_idx_d   = bus.Haddr[IDX_W+1:2];
                        dp_strb_d  = addr_strb;
`ifdef AHB_SUB_WAIT_EN
                        // Completion happens back in IDLE, so the counter covers only the low cycles
                        if (WAIT_CYCLES > 0) begin
                            state_d = SUB_WAIT;
                            cnt_d   = 4'(WAIT_CYCLES - 1);
                        end
`endif
                    end
                end
            end
`ifdef AHB_SUB_WAIT_EN
            SUB_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = SUB_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            SUB_ERR1: state_d = SUB_ERR2;
            default:  state_d = SUB_IDLE;
        endcase
    end

    // Control state; reset abandons any transfer in flight
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q    <= SUB_IDLE;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_idx_q   <= '0;
            dp_strb_q  <= '0;
`ifdef AHB_SUB_WAIT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            dp_valid_q <= dp_valid_d;
            dp_write_q <= dp_write_d;
            dp_idx_q   <= dp_idx_d;
            dp_strb_q  <= dp_strb_d;
`ifdef AHB_SUB_WAIT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    // Memory has no reset; a write lands on the edge that completes its data phase
    always_ff @(posedge Hclk) begin
        if (complete && dp_write_q) begin
            for (int i = 0; i < STRB_WIDTH; i++) begin
                if (dp_strb_q[i]) begin
                    mem[dp_idx_q][8*i +: 8] <= bus.Hwdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_sub.sv
// tb/tb_ahb_sram_sub.sv - directed and randomized checks of ahb_sram_sub against a memory model
module tb_ahb_sram_sub;
    import param_pkg::*;

    localparam int MEM_DEPTH   = 1024;
    localparam int WAIT_CYCLES = 2;
`ifdef AHB_SUB_WAIT_EN
    localparam int WEXP = WAIT_CYCLES;
`else
    localparam int WEXP = 0;
`endif
    localparam int NWORDS = 16;
    localparam int BOUND  = 40;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] ref_mem [MEM_DEPTH];

    ahb_sram_sub_if bus_if ();
    assign bus_if.Hready = bus_if.Hreadyout;

    ahb_sram_sub #(
        .MEM_DEPTH   (MEM_DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .Hclk    (clk),
        .Hresetn (rst_n),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [31:0] addr, input logic [2:0] size);
        if (size > 3'd2) return 1'b1;
        if ((addr % (32'd1 << size)) != 0) return 1'b1;
        if ((addr / 4) >= MEM_DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wdata,
                                          input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] mask;
        int nbytes;
        int off;
        nbytes = 1 << size;
        off    = int'(addr % 4);
        mask   = '0;
        for (int b = 0; b < 4; b++) begin
            if (b >= off && b < off + nbytes) mask |= 32'hFF << (8 * b);
        end
        return (old & ~mask) | (wdata & mask);
    endfunction

    task automatic drive_idle();
        bus_if.Hsel   = 1'b0;
        bus_if.Htrans = HTRANS_IDLE;
        bus_if.Hwrite = 1'b0;
        bus_if.Hsize  = 3'd0;
        bus_if.Haddr  = '0;
    endtask

    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output int low, output logic resp_low,
                        output logic resp_end, output logic [31:0] rdata);
        int n;
        @(negedge clk);
        bus_if.Hsel   = 1'b1;
        bus_if.Htrans = HTRANS_NONSEQ;
        bus_if.Haddr  = addr;
        bus_if.Hwrite = wr;
        bus_if.Hsize  = size;
        @(negedge clk);
        drive_idle();
        bus_if.Hwdata = wdata;
        low      = 0;
        resp_low = 1'b0;
        n        = 0;
        while (bus_if.Hreadyout !== 1'b1 && n < BOUND) begin
            low++;
            resp_low = resp_low | bus_if.Hresp;
            @(negedge clk);
            n++;
        end
        if (n >= BOUND) check("xfer_timeout", 32'(n), 32'(BOUND - 1));
        resp_end = bus_if.Hresp;
        rdata    = bus_if.Hrdata;
    endtask

    task automatic run(input string tag, input logic wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata, output logic [31:0] rdata);
        int   low;
        logic resp_low, resp_end;
        logic err;
        logic [31:0] exp_rd;
        err    = is_err(addr, size);
        exp_rd = (err || wr) ? 32'h0 : ref_mem[addr / 4];
        xfer(wr, addr, size, wdata, low, resp_low, resp_end, rdata);
        check($sformatf("%s.low_cycles", tag), 32'(low), err ? 32'd1 : 32'(WEXP));
        check($sformatf("%s.resp_low", tag), 32'(resp_low), err ? 32'd1 : 32'd0);
        check($sformatf("%s.resp_end", tag), 32'(resp_end), err ? 32'd1 : 32'd0);
        check($sformatf("%s.rdata", tag), rdata, exp_rd);
        if (!err && wr) ref_mem[addr / 4] = merge(ref_mem[addr / 4], wdata, addr, size);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        int   ap, dp, done, low, cyc;
        logic rdy, resp_bad;

        drive_idle();
        bus_if.Hwdata = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.hreadyout", 32'(bus_if.Hreadyout), 32'd1);
        check("reset.hresp", 32'(bus_if.Hresp), 32'd0);
        check("reset.hrdata", bus_if.Hrdata, 32'h0);
        rst_n = 1'b1;

        run("w_deadbeef", 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd);
        run("r_deadbeef", 1'b0, 32'h10, 3'd2, 32'h0, rd);
        check("r_deadbeef.vector", rd, 32'hDEADBEEF);

        run("w_11223344", 1'b1, 32'h10, 3'd2, 32'h11223344, rd);
        run("w_byte13", 1'b1, 32'h13, 3'd0, 32'hAA5A5A5A, rd);
        run("r_byte13", 1'b0, 32'h10, 3'd2, 32'h0, rd);
        check("r_byte13.vector", rd, 32'hAA223344);

        run("w_base0", 1'b1, 32'h00, 3'd2, 32'hCAFEF00D, rd);
        run("w_half01", 1'b1, 32'h01, 3'd1, 32'h12345678, rd);
        run("r_base0", 1'b0, 32'h00, 3'd2, 32'h0, rd);
        check("r_base0.vector", rd, 32'hCAFEF00D);

        run("r_oob", 1'b0, 32'(MEM_DEPTH * 4), 3'd2, 32'h0, rd);

        for (int i = 0; i < NWORDS; i++) begin
            run($sformatf("init%0d", i), 1'b1, 32'(i * 4), 3'd2, $urandom, rd);
        end
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 0) addr = 32'(MEM_DEPTH * 4) + 32'($urandom_range(0, 255));
            else                           addr = 32'($urandom_range(0, NWORDS * 4 - 1));
            size = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            run($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), addr, size, $urandom, rd);
        end

        run("w_old20", 1'b1, 32'h20, 3'd2, 32'h0BADCAFE, rd);
        @(negedge clk);
        bus_if.Hsel   = 1'b1;
        bus_if.Htrans = HTRANS_NONSEQ;
        bus_if.Haddr  = 32'h20;
        bus_if.Hwrite = 1'b1;
        bus_if.Hsize  = 3'd2;
        @(negedge clk);
        drive_idle();
        bus_if.Hwdata = 32'h55AA55AA;
        check("abort.pre_hreadyout", 32'(bus_if.Hreadyout), (WEXP > 0) ? 32'd0 : 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("abort.hreadyout", 32'(bus_if.Hreadyout), 32'd1);
        check("abort.hresp", 32'(bus_if.Hresp), 32'd0);
        check("abort.hrdata", bus_if.Hrdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run("r_old20", 1'b0, 32'h20, 3'd2, 32'h0, rd);
        check("r_old20.vector", rd, 32'h0BADCAFE);

        addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
        for (int i = 0; i < 3; i++) datas[i] = $urandom;
        ap = 0; dp = -1; done = 0; low = 0; cyc = 0; resp_bad = 1'b0;
        @(negedge clk);
        bus_if.Hsel   = 1'b1;
        bus_if.Htrans = HTRANS_NONSEQ;
        bus_if.Haddr  = addrs[0];
        bus_if.Hwrite = 1'b1;
        bus_if.Hsize  = 3'd2;
        while (done < 3 && cyc < BOUND) begin
            rdy = bus_if.Hreadyout;
            resp_bad = resp_bad | bus_if.Hresp;
            if (!rdy) low++;
            if (rdy && dp >= 0) done++;
            @(negedge clk);
            cyc++;
            if (rdy) begin
                if (ap < 3) begin
                    dp = ap;
                    bus_if.Hwdata = datas[ap];
                    ref_mem[addrs[ap] / 4] = datas[ap];
                end else begin
                    dp = -1;
                end
                ap++;
                if (ap < 3) begin
                    bus_if.Haddr  = addrs[ap];
                    bus_if.Htrans = HTRANS_NONSEQ;
                end else begin
                    drive_idle();
                end
            end
        end
        drive_idle();
        check("b2b.completions", 32'(done), 32'd3);
        check("b2b.low_cycles", 32'(low), 32'(3 * WEXP));
        check("b2b.total_cycles", 32'(cyc), 32'(1 + 3 * (WEXP + 1)));
        check("b2b.resp", 32'(resp_bad), 32'd0);
        for (int i = 0; i < 3; i++) begin
            run($sformatf("b2b_rd%0d", i), 1'b0, addrs[i], 3'd2, 32'h0, rd);
            check($sformatf("b2b_rd%0d.vector", i), rd, datas[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
